// File: rtl/clint_timer_mh_pkg.sv
// Shared register map, write-size encodings and byte-lane helpers for clint_timer_mh.
package clint_timer_mh_pkg;

    localparam logic [15:0] MSIP_BASE     = 16'h0000;
    localparam logic [15:0] MTIMECMP_BASE = 16'h4000;
    localparam logic [15:0] CTRL_ADDR     = 16'hBFF0;
    localparam logic [15:0] MTIME_LO      = 16'hBFF8;
    localparam logic [15:0] MTIME_HI      = 16'hBFFC;

    localparam int CTRL_RUN_BIT = 31;

    typedef enum logic [1:0] {
        WE_BYTE = 2'b00,
        WE_HALF = 2'b01,
        WE_WORD = 2'b10
    } we_size_e;

    // Bit mask of the byte lanes touched by a write of the given size at the given offset.
    function automatic logic [31:0] lane_mask(input logic [1:0] size, input logic [1:0] offs);
        logic [3:0]  lanes;
        logic [31:0] mask;
        case (we_size_e'(size))
            WE_BYTE: lanes = 4'b0001 << offs;
            WE_HALF: lanes = offs[1] ? 4'b1100 : 4'b0011;
            default: lanes = 4'b1111;
        endcase
        for (int i = 0; i < 4; i++) begin
            mask[i*8 +: 8] = {8{lanes[i]}};
        end
        return mask;
    endfunction

    function automatic logic [31:0] merge_lanes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [31:0] mask);
        return (old_val & ~mask) | (new_val & mask);
    endfunction

    function automatic logic [15:0] msip_addr(input int h);
        return MSIP_BASE + 16'(4 * h);
    endfunction

    function automatic logic [15:0] cmp_addr(input int h, input logic hi);
        return MTIMECMP_BASE + 16'(8 * h) + (hi ? 16'd4 : 16'd0);
    endfunction

endpackage

// File: rtl/clint_timer_mh_mtime.sv
// Free-running 64-bit mtime with prescaler, run gate and bus write override.
// CLINT_MTIME_SNAPSHOT_EN adds a high-word snapshot taken when the low word is read.
module clint_timer_mh_mtime #(
    parameter int PRESCALE_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ctrl_we,
    input  logic                  run_wdata,
    input  logic [PRESCALE_W-1:0] div_wdata,
    input  logic                  lo_we,
    input  logic                  hi_we,
    input  logic [31:0]           lo_wdata,
    input  logic [31:0]           hi_wdata,
    input  logic                  snap_rd,
    output logic [63:0]           mtime,
    output logic                  run,
    output logic [PRESCALE_W-1:0] div,
    output logic [31:0]           mtime_hi_rd
);
    localparam logic [PRESCALE_W-1:0] PCNT_ONE = 1;

    logic [PRESCALE_W-1:0] pcnt;
    logic                  tick;

    assign tick = run && (pcnt == div);

    // A bus write to mtime beats a same-cycle tick; any CTRL or mtime write restarts the prescaler.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mtime <= '0;
            pcnt  <= '0;
            run   <= 1'b1;
            div   <= '0;
        end else begin
            if (run) begin
                pcnt <= tick ? '0 : pcnt + PCNT_ONE;
            end
            if (ctrl_we) begin
                run <= run_wdata;
                div <= div_wdata;
            end
            if (ctrl_we || lo_we || hi_we) begin
                pcnt <= '0;
            end
            if (lo_we || hi_we) begin
                if (lo_we) mtime[31:0]  <= lo_wdata;
                if (hi_we) mtime[63:32] <= hi_wdata;
            end else if (tick) begin
                mtime <= mtime + 64'd1;
            end
        end
    end

`ifdef CLINT_MTIME_SNAPSHOT_EN
    logic [31:0] snap_hi;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_hi <= '0;
        end else if (hi_we) begin
            snap_hi <= hi_wdata;
        end else if (lo_we || snap_rd) begin
            snap_hi <= mtime[63:32];
        end
    end

    assign mtime_hi_rd = snap_hi;
`else
    logic unused_snap_rd;

    assign unused_snap_rd = snap_rd;
    assign mtime_hi_rd    = mtime[63:32];
`endif

endmodule

// File: rtl/clint_timer_mh.sv
// Multi-hart CLINT-style timer: decode, per-hart msip/mtimecmp, compare and read mux.
// Define CLINT_MTIME_SNAPSHOT_EN for a tear-free 64-bit mtime read via a high-word snapshot.
module clint_timer_mh
    import clint_timer_mh_pkg::*;
#(
    parameter int NHART      = 1,
    parameter int PRESCALE_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sel,
    input  logic [15:0]      addr,
    input  logic [2:0]       we,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata,
    output logic [63:0]      mtime_o,
    output logic [NHART-1:0] mtip,
    output logic [NHART-1:0] msip_irq
);
    logic [15:0]           word_addr;
    logic                  wr;
    logic                  rd;
    logic [31:0]           wmask;
    logic                  run;
    logic [PRESCALE_W-1:0] div;
    logic [63:0]           mtime;
    logic [31:0]           mtime_hi_rd;
    logic [31:0]           ctrl_rd;
    logic [31:0]           ctrl_new;
    logic                  unused_ctrl_bits;
    logic [31:0]           rdata_mux;

    logic [63:0] mtimecmp   [NHART];
    logic        msip_q     [NHART];
    logic        mtip_q     [NHART];
    logic        msip_irq_q [NHART];

    assign word_addr = {addr[15:2], 2'b00};
    assign wr        = sel & we[2];
    assign rd        = sel & ~we[2];
    assign wmask     = lane_mask(we[1:0], addr[1:0]);

    assign ctrl_rd          = {run, {(31-PRESCALE_W){1'b0}}, div};
    assign ctrl_new         = merge_lanes(ctrl_rd, wdata, wmask);
    assign unused_ctrl_bits = ^ctrl_new[30:PRESCALE_W];

    clint_timer_mh_mtime #(.PRESCALE_W(PRESCALE_W)) u_mtime (
        .clk         (clk),
        .rst_n       (rst_n),
        .ctrl_we     (wr && (word_addr == CTRL_ADDR)),
        .run_wdata   (ctrl_new[CTRL_RUN_BIT]),
        .div_wdata   (ctrl_new[PRESCALE_W-1:0]),
        .lo_we       (wr && (word_addr == MTIME_LO)),
        .hi_we       (wr && (word_addr == MTIME_HI)),
        .lo_wdata    (merge_lanes(mtime[31:0], wdata, wmask)),
        .hi_wdata    (merge_lanes(mtime[63:32], wdata, wmask)),
        .snap_rd     (rd && (word_addr == MTIME_LO)),
        .mtime       (mtime),
        .run         (run),
        .div         (div),
        .mtime_hi_rd (mtime_hi_rd)
    );

    assign mtime_o = mtime;

    for (genvar h = 0; h < NHART; h++) begin : g_hart
        // Interrupt lines are registered views of the compare result and of msip.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                msip_q[h]     <= 1'b0;
                mtimecmp[h]   <= '1;
                mtip_q[h]     <= 1'b0;
                msip_irq_q[h] <= 1'b0;
            end else begin
                mtip_q[h]     <= (mtime >= mtimecmp[h]);
                msip_irq_q[h] <= msip_q[h];
                if (wr && (word_addr == msip_addr(h)) && wmask[0]) begin
                    msip_q[h] <= wdata[0];
                end
                if (wr && (word_addr == cmp_addr(h, 1'b0))) begin
                    mtimecmp[h][31:0] <= merge_lanes(mtimecmp[h][31:0], wdata, wmask);
                end
                if (wr && (word_addr == cmp_addr(h, 1'b1))) begin
                    mtimecmp[h][63:32] <= merge_lanes(mtimecmp[h][63:32], wdata, wmask);
                end
            end
        end

        assign mtip[h]     = mtip_q[h];
        assign msip_irq[h] = msip_irq_q[h];
    end

    // Unmapped addresses, including harts beyond NHART, contribute nothing to the OR-mux.
    always_comb begin
        rdata_mux = '0;
        for (int h = 0; h < NHART; h++) begin
            if (word_addr == msip_addr(h))       rdata_mux = rdata_mux | {31'b0, msip_q[h]};
            if (word_addr == cmp_addr(h, 1'b0))  rdata_mux = rdata_mux | mtimecmp[h][31:0];
            if (word_addr == cmp_addr(h, 1'b1))  rdata_mux = rdata_mux | mtimecmp[h][63:32];
        end
        if (word_addr == CTRL_ADDR) rdata_mux = rdata_mux | ctrl_rd;
        if (word_addr == MTIME_LO)  rdata_mux = rdata_mux | mtime[31:0];
        if (word_addr == MTIME_HI)  rdata_mux = rdata_mux | mtime_hi_rd;
    end

    assign rdata = (sel && rst_n) ? rdata_mux : 32'h0;

endmodule

// File: tb/tb_clint_timer_mh.sv
// Scoreboard bench for clint_timer_mh (NHART=2): directed scenarios plus random bus traffic
// checked against a register-level reference model; honours CLINT_MTIME_SNAPSHOT_EN.
module tb_clint_timer_mh;

    localparam int NHART = 2;
    localparam int PW    = 16;

    logic             clk;
    logic             rst_n;
    logic             sel;
    logic [15:0]      addr;
    logic [2:0]       we;
    logic [31:0]      wdata;
    logic [31:0]      rdata;
    logic [63:0]      mtime_o;
    logic [NHART-1:0] mtip;
    logic [NHART-1:0] msip_irq;

    clint_timer_mh #(.NHART(NHART), .PRESCALE_W(PW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sel      (sel),
        .addr     (addr),
        .we       (we),
        .wdata    (wdata),
        .rdata    (rdata),
        .mtime_o  (mtime_o),
        .mtip     (mtip),
        .msip_irq (msip_irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [15:0]      addr;
        logic [31:0]      rdata;
        logic [63:0]      mtime;
        logic [NHART-1:0] mtip;
        logic [NHART-1:0] irq;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;

    // Reference model: architectural register contents, advanced once per clock.
    logic [63:0]      m_time;
    logic [15:0]      m_pcnt;
    logic [15:0]      m_div;
    logic             m_run;
    logic [NHART-1:0] m_msip;
    logic [NHART-1:0] m_mtip;
    logic [NHART-1:0] m_irq;
    logic [63:0]      m_cmp [NHART];
    logic [31:0]      m_snap;

    function automatic void model_reset();
        m_time = 64'h0;
        m_pcnt = 16'h0;
        m_div  = 16'h0;
        m_run  = 1'b1;
        m_msip = '0;
        m_mtip = '0;
        m_irq  = '0;
        m_snap = 32'h0;
        for (int h = 0; h < NHART; h++) m_cmp[h] = '1;
    endfunction

    // Replace the bytes of 'old' that a write of size sz at address a touches.
    function automatic logic [31:0] put_bytes(input logic [31:0] old, input logic [15:0] a,
                                              input logic [1:0] sz, input logic [31:0] d);
        logic [31:0] r;
        int first;
        int n;
        r = old;
        case (sz)
            2'b00:   begin first = int'(a % 16'd4);              n = 1; end
            2'b01:   begin first = (a % 16'd4 >= 16'd2) ? 2 : 0; n = 2; end
            default: begin first = 0;                            n = 4; end
        endcase
        for (int i = first; i < first + n; i++) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    function automatic logic [31:0] model_read(input logic [15:0] a);
        int w;
        int h;
        w = int'(a) & 32'hFFFC;
        if (w < 'h4000) begin
            if (w / 4 < NHART) return {31'b0, m_msip[w/4]};
            return 32'h0;
        end
        if (w < 'h4000 + 8 * NHART) begin
            h = (w - 'h4000) / 8;
            if (w % 8 == 4) return m_cmp[h][63:32];
            return m_cmp[h][31:0];
        end
        if (w == 'hBFF0) return {m_run, 15'b0, m_div};
        if (w == 'hBFF8) return m_time[31:0];
`ifdef CLINT_MTIME_SNAPSHOT_EN
        if (w == 'hBFFC) return m_snap;
`else
        if (w == 'hBFFC) return m_time[63:32];
`endif
        return 32'h0;
    endfunction

    function automatic void model_step(input logic s, input logic [15:0] a,
                                       input logic [2:0] w, input logic [31:0] d);
        logic [63:0] t_next;
        logic [15:0] p_next;
        logic [31:0] v;
        int wd;
        int h;
        t_next = m_time;
        p_next = m_pcnt;
        if (m_run) begin
            if (m_pcnt == m_div) begin
                t_next = m_time + 64'd1;
                p_next = 16'h0;
            end else begin
                p_next = m_pcnt + 16'd1;
            end
        end
        for (int i = 0; i < NHART; i++) m_mtip[i] = (m_time >= m_cmp[i]);
        m_irq = m_msip;
        wd = int'(a) & 32'hFFFC;
        if (s && !w[2] && wd == 'hBFF8) m_snap = m_time[63:32];
        if (s && w[2]) begin
            if (wd < 'h4000) begin
                if (wd / 4 < NHART) begin
                    v = put_bytes({31'b0, m_msip[wd/4]}, a, w[1:0], d);
                    m_msip[wd/4] = v[0];
                end
            end else if (wd < 'h4000 + 8 * NHART) begin
                h = (wd - 'h4000) / 8;
                if (wd % 8 == 4) m_cmp[h][63:32] = put_bytes(m_cmp[h][63:32], a, w[1:0], d);
                else             m_cmp[h][31:0]  = put_bytes(m_cmp[h][31:0], a, w[1:0], d);
            end else if (wd == 'hBFF0) begin
                v = put_bytes({m_run, 15'b0, m_div}, a, w[1:0], d);
                m_run  = v[31];
                m_div  = v[15:0];
                p_next = 16'h0;
            end else if (wd == 'hBFF8) begin
                t_next = {m_time[63:32], put_bytes(m_time[31:0], a, w[1:0], d)};
                p_next = 16'h0;
                m_snap = t_next[63:32];
            end else if (wd == 'hBFFC) begin
                t_next = {put_bytes(m_time[63:32], a, w[1:0], d), m_time[31:0]};
                p_next = 16'h0;
                m_snap = t_next[63:32];
            end
        end
        m_time = t_next;
        m_pcnt = p_next;
    endfunction

    task automatic applyStimulus(input logic s, input logic [15:0] a,
                                 input logic [2:0] w, input logic [31:0] d);
        exp_t e;
        sel   = s;
        addr  = a;
        we    = w;
        wdata = d;
        e.addr  = a;
        e.rdata = s ? model_read(a) : 32'h0;
        e.mtime = m_time;
        e.mtip  = m_mtip;
        e.irq   = m_irq;
        sb_q.push_back(e);
        model_step(s, a, w, d);
        @(posedge clk);
        #1;
    endtask

    task automatic doReset(input int n);
        exp_t e;
        rst_n = 1'b0;
        model_reset();
        repeat (n) begin
            sel   = 1'b1;
            addr  = 16'h4000;
            we    = 3'b010;
            wdata = 32'h0;
            e.addr  = 16'h4000;
            e.rdata = 32'h0;
            e.mtime = 64'h0;
            e.mtip  = '0;
            e.irq   = '0;
            sb_q.push_back(e);
            @(posedge clk);
            #1;
        end
        rst_n = 1'b1;
    endtask

    task automatic checkOutput(input exp_t e);
        checks++;
        if (rdata !== e.rdata) begin
            failures++;
            $display("[TB] FAIL rdata addr=%h got=%h exp=%h", e.addr, rdata, e.rdata);
        end
        checks++;
        if (mtime_o !== e.mtime) begin
            failures++;
            $display("[TB] FAIL mtime_o got=%h exp=%h", mtime_o, e.mtime);
        end
        checks++;
        if (mtip !== e.mtip) begin
            failures++;
            $display("[TB] FAIL mtip got=%b exp=%b", mtip, e.mtip);
        end
        checks++;
        if (msip_irq !== e.irq) begin
            failures++;
            $display("[TB] FAIL msip_irq got=%b exp=%b", msip_irq, e.irq);
        end
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            checkOutput(mon_e);
        end
    end

    task automatic randomOp();
        logic        s;
        logic [15:0] a;
        logic [2:0]  w;
        logic [31:0] d;
        int k;
        k = $urandom_range(0, 11);
        case (k)
            0:       a = 16'h0000;
            1:       a = 16'h0004;
            2:       a = 16'h0008;
            3:       a = 16'h4000;
            4:       a = 16'h4004;
            5:       a = 16'h4008;
            6:       a = 16'h400C;
            7:       a = 16'h4010;
            8:       a = 16'hBFF0;
            9:       a = 16'hBFF8;
            10:      a = 16'hBFFC;
            default: a = 16'($urandom);
        endcase
        a[1:0] = 2'($urandom_range(0, 3));
        s = ($urandom_range(0, 9) >= 2);
        w = {($urandom_range(0, 9) < 4), 2'($urandom_range(0, 2))};
        d = $urandom;
        if (k == 8) begin
            d = {($urandom_range(0, 4) != 0), 15'($urandom), 16'($urandom_range(0, 3))};
        end else if (k == 3 || k == 5) begin
            d = m_time[31:0] + 32'($urandom_range(0, 40));
        end else if (k == 4 || k == 6) begin
            d = ($urandom_range(0, 3) == 0) ? $urandom : m_time[63:32];
        end else if (k == 9) begin
            d = ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15)) : $urandom;
        end else if (k == 10) begin
            case ($urandom_range(0, 2))
                0:       d = 32'hFFFF_FFFF;
                1:       d = 32'h0;
                default: d = m_time[63:32];
            endcase
        end
        applyStimulus(s, a, w, d);
    endtask

    initial begin
        rst_n = 1'b0;
        sel   = 1'b0;
        addr  = 16'h0;
        we    = 3'b000;
        wdata = 32'h0;
        model_reset();
        @(posedge clk);
        #1;
        doReset(3);

        // Free run at div=0, then read mtime
        repeat (10) applyStimulus(1'b0, 16'h0, 3'b000, 32'h0);
        applyStimulus(1'b1, 16'hBFF8, 3'b010, 32'h0);

        // Prescaler div=3, then stopped, then back to full speed
        applyStimulus(1'b1, 16'hBFF0, 3'b110, 32'h8000_0003);
        repeat (12) applyStimulus(1'b1, 16'hBFF8, 3'b010, 32'h0);
        applyStimulus(1'b1, 16'hBFF0, 3'b110, 32'h0000_0003);
        repeat (5) applyStimulus(1'b1, 16'hBFF8, 3'b010, 32'h0);
        applyStimulus(1'b1, 16'hBFF0, 3'b110, 32'h8000_0000);

        // Hart 1 compare at 0x20, later raised to 0x40
        applyStimulus(1'b1, 16'hBFFC, 3'b110, 32'h0);
        applyStimulus(1'b1, 16'hBFF8, 3'b110, 32'h0);
        applyStimulus(1'b1, 16'h4008, 3'b110, 32'h20);
        applyStimulus(1'b1, 16'h400C, 3'b110, 32'h0);
        repeat (40) applyStimulus(1'b0, 16'h0, 3'b000, 32'h0);
        applyStimulus(1'b1, 16'h4008, 3'b110, 32'h40);
        repeat (3) applyStimulus(1'b1, 16'h4008, 3'b010, 32'h0);

        // Wrap of mtime with hart 0 compare at 0x10
        applyStimulus(1'b1, 16'h4000, 3'b110, 32'h10);
        applyStimulus(1'b1, 16'h4004, 3'b110, 32'h0);
        applyStimulus(1'b1, 16'hBFFC, 3'b110, 32'hFFFF_FFFF);
        applyStimulus(1'b1, 16'hBFF8, 3'b110, 32'hFFFF_FFFE);
        repeat (5) applyStimulus(1'b1, 16'hBFFC, 3'b010, 32'h0);

        // Sub-word writes into mtimecmp[0], msip, and an absent hart
        applyStimulus(1'b1, 16'h4000, 3'b110, 32'hFFFF_FFFF);
        applyStimulus(1'b1, 16'h4004, 3'b110, 32'hFFFF_FFFF);
        applyStimulus(1'b1, 16'h4001, 3'b100, 32'h0000_A500);
        applyStimulus(1'b1, 16'h4006, 3'b101, 32'h1234_0000);
        applyStimulus(1'b1, 16'h4000, 3'b010, 32'h0);
        applyStimulus(1'b1, 16'h4004, 3'b010, 32'h0);
        applyStimulus(1'b1, 16'h0000, 3'b110, 32'h1);
        repeat (2) applyStimulus(1'b1, 16'h0000, 3'b010, 32'h0);
        applyStimulus(1'b1, 16'h0008, 3'b110, 32'h1);
        applyStimulus(1'b1, 16'h0008, 3'b010, 32'h0);

        // Low/high read across a carry out of the low word
        applyStimulus(1'b1, 16'hBFFC, 3'b110, 32'h0);
        applyStimulus(1'b1, 16'hBFF8, 3'b110, 32'hFFFF_FFFF);
        applyStimulus(1'b1, 16'hBFF8, 3'b010, 32'h0);
        applyStimulus(1'b1, 16'hBFFC, 3'b010, 32'h0);

        // Reset in the middle of activity, then random traffic
        doReset(2);
        repeat (1500) randomOp();
        doReset(1);
        repeat (300) randomOp();

        sel = 1'b0;
        we  = 3'b000;
        for (int i = 0; i < 5 && sb_q.size() > 0; i++) @(negedge clk);
        if (sb_q.size() > 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL scoreboard_drain left=%0d exp=0", sb_q.size());
        end
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
